// File: rtl/dma_rd_streamer_if.sv
// Read-request channel between the DMA read streamer and the AXI master read
// port. One request is one burst: start address, beats-1, beat size, a byte
// strobe applied to every beat of the burst, and the burst mode.
//
// Handshake: rd_req_valid is raised by the master with all rd_req_* fields
// stable. Valid and fields are held until a cycle with rd_req_valid &&
// rd_req_ready, and that cycle is the transfer. Valid is never withdrawn
// before the transfer. Ready may be driven independently of valid.
//
// Signals:
//   rd_req_valid  master->slave  request valid
//   rd_req_ready  slave->master  request accepted
//   rd_req_addr   master->slave  burst start address
//   rd_req_alen   master->slave  beats-1
//   rd_req_size   master->slave  log2(bytes per beat)
//   rd_req_strb   master->slave  byte mask for every beat of the burst
//   rd_req_mode   master->slave  0=FIXED, 1=INCR
`timescale 1ns/1ps
interface dma_rd_streamer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BPB = DATA_WIDTH / 8;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic [7:0]            rd_req_alen;
    logic [2:0]            rd_req_size;
    logic [BPB-1:0]        rd_req_strb;
    logic                  rd_req_mode;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_alen, rd_req_size,
               rd_req_strb, rd_req_mode,
        input  rd_req_ready
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_alen, rd_req_size,
               rd_req_strb, rd_req_mode,
        output rd_req_ready
    );
endinterface

// File: rtl/dma_rd_streamer.sv
// Read-side DMA streamer. Turns one descriptor (source address, byte count,
// mode) into a sequence of AXI-legal read burst requests. Bursts never cross
// a 4KB page, never exceed MAX_BEATS (INCR) or 16 beats (FIXED), and a
// partial final beat is issued as its own single-beat burst with a narrowed
// strobe, because the downstream port applies one strobe to every beat.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start_i        descriptor strobe, sampled only in IDLE
//   src_addr_i     source start address (must be beat aligned)
//   num_bytes_i    bytes to transfer
//   mode_i         0=FIXED, 1=INCR
//   abort_i        abort request (level)
//   rd             read-request channel (master side)
//   busy_o         descriptor in progress
//   done_o         one-cycle completion pulse
//   aborted_o      with done_o: run ended by abort
//   err_o          with done_o: start address not beat aligned
//   req_cnt_o      bursts issued this run (wraps)
//   dbg_state_o    current FSM state (0 IDLE, 1 CALC, 2 REQ, 3 DONE)
`timescale 1ns/1ps
module dma_rd_streamer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTES_WIDTH = 32,
    parameter int MAX_BEATS   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_WIDTH-1:0]  src_addr_i,
    input  logic [BYTES_WIDTH-1:0] num_bytes_i,
    input  logic                   mode_i,
    input  logic                   abort_i,
    dma_rd_streamer_if.master      rd,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   aborted_o,
    output logic                   err_o,
    output logic [15:0]            req_cnt_o,
    output logic [1:0]             dbg_state_o
);
    localparam int BPB  = DATA_WIDTH / 8;
    localparam int SIZE = $clog2(BPB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BYTES_WIDTH-1:0] full_q, full_d;
    logic [SIZE-1:0]        tail_q, tail_d;
    logic                   mode_q, mode_d;
    logic [8:0]             beats_q, beats_d;
    logic                   abort_lat_q, abort_lat_d;
    logic                   req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [7:0]             req_alen_q, req_alen_d;
    logic [2:0]             req_size_q, req_size_d;
    logic [BPB-1:0]         req_strb_q, req_strb_d;
    logic                   req_mode_q, req_mode_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   err_q, err_d;
    logic [15:0]            req_cnt_q, req_cnt_d;

    // Helpers for burst sizing from the current (aligned) address.
    logic [12:0]            page_rem;
    logic [12:0]            page_beats;
    logic [12:0]            limit;
    logic [8:0]             calc_beats;
    logic [8:0]             nb_m1;
    logic [BPB-1:0]         tail_strb;
    logic [BYTES_WIDTH-1:0] full_after;
    logic                   hs;
    logic                   last;
    logic                   stop_abort;

    always_comb begin
        // Beats left before the next 4KB page boundary.
        page_rem   = 13'd4096 - {1'b0, addr_q[11:0]};
        page_beats = page_rem >> SIZE;
        if (mode_q) begin
            limit = (page_beats < 13'(MAX_BEATS)) ? page_beats : 13'(MAX_BEATS);
        end else begin
            limit = 13'd16;
        end
        if (full_q < BYTES_WIDTH'(limit)) begin
            calc_beats = 9'(full_q);
        end else begin
            calc_beats = 9'(limit);
        end
        for (int i = 0; i < BPB; i++) begin
            tail_strb[i] = (i < int'(tail_q));
        end
        full_after = full_q - BYTES_WIDTH'(beats_q);
        hs         = req_valid_q & rd.rd_req_ready;
        stop_abort = abort_lat_q | abort_i;
        // The handshaken burst was the last one when nothing remains.
        last       = (full_q != '0) ? ((full_after == '0) && (tail_q == '0)) : 1'b1;
        nb_m1      = 9'd0;

        state_d     = state_q;
        addr_d      = addr_q;
        full_d      = full_q;
        tail_d      = tail_q;
        mode_d      = mode_q;
        beats_d     = beats_q;
        abort_lat_d = abort_lat_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_alen_d  = req_alen_q;
        req_size_d  = req_size_q;
        req_strb_d  = req_strb_q;
        req_mode_d  = req_mode_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        err_d       = err_q;
        req_cnt_d   = req_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d      = src_addr_i;
                    mode_d      = mode_i;
                    full_d      = num_bytes_i >> SIZE;
                    tail_d      = num_bytes_i[SIZE-1:0];
                    req_cnt_d   = 16'd0;
                    busy_d      = 1'b1;
                    req_size_d  = 3'(SIZE);
                    abort_lat_d = 1'b0;
                    aborted_d   = 1'b0;
                    err_d       = 1'b0;
                    if (src_addr_i[SIZE-1:0] != '0) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (num_bytes_i == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (abort_i) begin
                    aborted_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    if (full_q != '0) begin
                        beats_d    = calc_beats;
                        req_strb_d = '1;
                    end else begin
                        // Only a partial beat remains: single narrowed beat.
                        beats_d    = 9'd1;
                        req_strb_d = tail_strb;
                    end
                    nb_m1       = beats_d - 9'd1;
                    req_alen_d  = nb_m1[7:0];
                    req_addr_d  = addr_q;
                    req_mode_d  = mode_q;
                    req_valid_d = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (abort_i) begin
                    abort_lat_d = 1'b1;
                end
                if (hs) begin
                    req_valid_d = 1'b0;
                    req_cnt_d   = req_cnt_q + 16'd1;
                    if (full_q != '0) begin
                        full_d = full_after;
                        if (mode_q) begin
                            addr_d = addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
                        end
                    end else begin
                        tail_d = '0;
                    end
                    if (stop_abort || last) begin
                        aborted_d = stop_abort;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                busy_d    = 1'b0;
                aborted_d = 1'b0;
                err_d     = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            full_q      <= '0;
            tail_q      <= '0;
            mode_q      <= 1'b0;
            beats_q     <= '0;
            abort_lat_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_alen_q  <= '0;
            req_size_q  <= '0;
            req_strb_q  <= '0;
            req_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            req_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            full_q      <= full_d;
            tail_q      <= tail_d;
            mode_q      <= mode_d;
            beats_q     <= beats_d;
            abort_lat_q <= abort_lat_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_alen_q  <= req_alen_d;
            req_size_q  <= req_size_d;
            req_strb_q  <= req_strb_d;
            req_mode_q  <= req_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
            req_cnt_q   <= req_cnt_d;
        end
    end

    assign rd.rd_req_valid = req_valid_q;
    assign rd.rd_req_addr  = req_addr_q;
    assign rd.rd_req_alen  = req_alen_q;
    assign rd.rd_req_size  = req_size_q;
    assign rd.rd_req_strb  = req_strb_q;
    assign rd.rd_req_mode  = req_mode_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign aborted_o       = aborted_q;
    assign err_o           = err_q;
    assign req_cnt_o       = req_cnt_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_dma_rd_streamer.sv
// Bench for dma_rd_streamer: directed descriptors plus a few random ones,
// with expected burst requests queued at stimulus time and checked when the
// DUT hands each request over.
`timescale 1ns/1ps
module tb_dma_rd_streamer;
    localparam int EW = 48;  // {addr[31:0], alen[7:0], strb[3:0], size[2:0], mode}

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] src_addr_i;
    logic [31:0] num_bytes_i;
    logic        mode_i;
    logic        abort_i;
    logic        busy_o, done_o, aborted_o, err_o;
    logic [15:0] req_cnt_o;
    logic [1:0]  dbg_state_o;

    dma_rd_streamer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rd_if ();

    dma_rd_streamer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTES_WIDTH(32), .MAX_BEATS(256)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i),
        .num_bytes_i(num_bytes_i), .mode_i(mode_i), .abort_i(abort_i),
        .rd(rd_if), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
        .err_o(err_o), .req_cnt_o(req_cnt_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] pack_req(logic [31:0] a, logic [7:0] alen,
                                               logic [3:0] strb, logic m);
        return {a, alen, strb, 3'd2, m};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    logic [EW-1:0] cur_req;
    logic [EW-1:0] held_req;
    logic          stall_prev = 1'b0;
    assign cur_req = {rd_if.rd_req_addr, rd_if.rd_req_alen, rd_if.rd_req_strb,
                      rd_if.rd_req_size, rd_if.rd_req_mode};

    // Request monitor: stall stability and handshake comparison.
    always @(negedge clk) begin
        if (rd_if.rd_req_valid && stall_prev) chk("req_stable", 64'(cur_req), 64'(held_req));
        if (rd_if.rd_req_valid && rd_if.rd_req_ready) begin
            chk("req_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) chk("req_fields", 64'(cur_req), 64'(exp_q.pop_front()));
        end
        stall_prev <= rd_if.rd_req_valid && !rd_if.rd_req_ready;
        held_req   <= cur_req;
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [31:0] a, input logic [31:0] n, input logic m);
        @(posedge clk); #1;
        start_i = 1'b1; src_addr_i = a; num_bytes_i = n; mode_i = m;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_ready, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd_ready) rd_if.rd_req_ready = 1'($urandom_range(0, 1));
        end
        chk("done_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rd_if.rd_req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("valid_seen", 64'(ok), 64'd1);
    endtask

    task automatic push_model(input logic [31:0] a0, input int n, input logic m, output int cnt);
        logic [31:0] a;
        int f, t, b, pg;
        a = a0; f = n / 4; t = n % 4; cnt = 0;
        while (f > 0) begin
            pg = (4096 - int'(a[11:0])) / 4;
            b  = f;
            if (m) begin
                if (b > 256) b = 256;
                if (b > pg) b = pg;
            end else if (b > 16) begin
                b = 16;
            end
            exp_q.push_back(pack_req(a, 8'(b - 1), 4'hF, m));
            cnt++;
            f -= b;
            if (m) a = a + 32'(b * 4);
        end
        if (t > 0) begin
            exp_q.push_back(pack_req(a, 8'd0, 4'((1 << t) - 1), m));
            cnt++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int vcnt, ncnt;
        logic [31:0] ra;
        int rn;
        logic rm;

        rst = 1'b1; start_i = 1'b0; src_addr_i = '0; num_bytes_i = '0;
        mode_i = 1'b0; abort_i = 1'b0; rd_if.rd_req_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(rd_if.rd_req_valid), 64'd0);
        chk("rst_req",   64'(cur_req), 64'd0);
        chk("rst_flags", 64'({busy_o, done_o, aborted_o, err_o}), 64'd0);
        chk("rst_cnt",   64'(req_cnt_o), 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // 64B INCR at 0x1000, exact latency
        exp_q.push_back(pack_req(32'h1000, 8'd15, 4'hF, 1'b1));
        start_run(32'h1000, 64, 1'b1);
        @(negedge clk);
        chk("t1_calc_valid", 64'(rd_if.rd_req_valid), 64'd0);
        chk("t1_busy", 64'(busy_o), 64'd1);
        chk("t1_state_calc", 64'(dbg_state_o), 64'd1);
        @(negedge clk);
        chk("t1_first_valid", 64'(rd_if.rd_req_valid), 64'd1);
        @(negedge clk);
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_cnt", 64'(req_cnt_o), 64'd1);
        chk("t1_ab_err", 64'({aborted_o, err_o}), 64'd0);
        chk("t1_valid_drop", 64'(rd_if.rd_req_valid), 64'd0);
        @(negedge clk);
        chk("t1_idle", 64'({busy_o, done_o}), 64'd0);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // 64B INCR straddling a 4KB page
        exp_q.push_back(pack_req(32'h0FF0, 8'd3, 4'hF, 1'b1));
        exp_q.push_back(pack_req(32'h1000, 8'd11, 4'hF, 1'b1));
        start_run(32'h0FF0, 64, 1'b1);
        wait_done(1'b0, ok);
        chk("t2_cnt", 64'(req_cnt_o), 64'd2);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // 1030B INCR: max burst, full beat, partial tail
        exp_q.push_back(pack_req(32'h2000, 8'd255, 4'hF, 1'b1));
        exp_q.push_back(pack_req(32'h2400, 8'd0, 4'hF, 1'b1));
        exp_q.push_back(pack_req(32'h2404, 8'd0, 4'h3, 1'b1));
        start_run(32'h2000, 1030, 1'b1);
        wait_done(1'b0, ok);
        chk("t3_cnt", 64'(req_cnt_o), 64'd3);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 40B FIXED with ready held low for 5 cycles
        rd_if.rd_req_ready = 1'b0;
        exp_q.push_back(pack_req(32'h3000, 8'd9, 4'hF, 1'b0));
        start_run(32'h3000, 40, 1'b0);
        wait_valid(ok);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_valid_held", 64'(rd_if.rd_req_valid), 64'd1);
        end
        @(posedge clk); #1; rd_if.rd_req_ready = 1'b1;
        wait_done(1'b0, ok);
        chk("t4_cnt", 64'(req_cnt_o), 64'd1);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // Abort pulse while the first 1030B burst is stalled
        rd_if.rd_req_ready = 1'b0;
        exp_q.push_back(pack_req(32'h2000, 8'd255, 4'hF, 1'b1));
        start_run(32'h2000, 1030, 1'b1);
        wait_valid(ok);
        @(posedge clk); #1; abort_i = 1'b1;
        @(posedge clk); #1; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_valid_kept", 64'(rd_if.rd_req_valid), 64'd1);
        chk("t5_state_req", 64'(dbg_state_o), 64'd2);
        @(posedge clk); #1; rd_if.rd_req_ready = 1'b1;
        wait_done(1'b0, ok);
        chk("t5_aborted", 64'(aborted_o), 64'd1);
        chk("t5_cnt", 64'(req_cnt_o), 64'd1);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd_if.rd_req_valid) vcnt++;
        end
        chk("t5_no_more_valid", 64'(vcnt), 64'd0);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // Abort in IDLE has no effect
        @(posedge clk); #1; abort_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_idle_abort", 64'({dbg_state_o, busy_o, done_o}), 64'd0);
        @(posedge clk); #1; abort_i = 1'b0;

        // Zero-byte descriptor
        start_run(32'h4000, 0, 1'b1);
        @(negedge clk);
        chk("t7_done", 64'(done_o), 64'd1);
        chk("t7_err_valid", 64'({err_o, rd_if.rd_req_valid}), 64'd0);
        chk("t7_cnt", 64'(req_cnt_o), 64'd0);

        // Unaligned start address
        start_run(32'h1002, 16, 1'b1);
        @(negedge clk);
        chk("t8_done_err", 64'({done_o, err_o}), 64'd3);
        chk("t8_no_valid", 64'(rd_if.rd_req_valid), 64'd0);
        @(negedge clk);

        // Random descriptors with random ready
        for (int r = 0; r < 6; r++) begin
            ra = 32'($urandom_range(0, 32'h3FFF)) & 32'hFFFF_FFFC;
            rn = $urandom_range(1, 1200);
            rm = 1'($urandom_range(0, 1));
            push_model(ra, rn, rm, ncnt);
            start_run(ra, 32'(rn), rm);
            wait_done(1'b1, ok);
            chk("rnd_cnt", 64'(req_cnt_o), 64'(ncnt));
            chk("rnd_q_empty", 64'(exp_q.size()), 64'd0);
            rd_if.rd_req_ready = 1'b1;
            @(negedge clk);
        end

        // Asynchronous reset while a request is stalled
        rd_if.rd_req_ready = 1'b0;
        start_run(32'h5000, 64, 1'b1);
        wait_valid(ok);
        #1 rst = 1'b1;
        #1;
        chk("t9_rst_valid", 64'(rd_if.rd_req_valid), 64'd0);
        chk("t9_rst_req", 64'(cur_req), 64'd0);
        chk("t9_rst_flags", 64'({busy_o, done_o, aborted_o, err_o}), 64'd0);
        chk("t9_rst_state", 64'(dbg_state_o), 64'd0);
        exp_q.delete();
        @(posedge clk); #1; rst = 1'b0; rd_if.rd_req_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dma_rd_streamer.md
Name: dma_rd_streamer

Overview:
Read-side streamer that turns one DMA descriptor (source address, byte count, mode) into a sequence of AXI-legal burst requests. It sits between the DMA FSM and the read-request port of the DMA AXI master interface. It splits transfers at 4KB boundaries and at the maximum burst length, and isolates any partial final beat into its own single-beat burst with a narrowed strobe, because the AXI interface applies one strobe to every beat of a request.

Parameters:
ADDR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, AXI data width in bits; BPB = DATA_WIDTH/8 bytes per beat (power of 2, >=2)
BYTES_WIDTH, 32, width of the descriptor byte count
MAX_BEATS, 256, maximum INCR burst length in beats (1..256); FIXED bursts are capped at 16

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start_i  input  1  descriptor strobe; sampled only in IDLE
src_addr_i  input  ADDR_WIDTH  source start address
num_bytes_i  input  BYTES_WIDTH  bytes to transfer
mode_i  input  1  0=FIXED, 1=INCR
abort_i  input  1  abort request (level)
rd_req_valid_o  output  1  burst request valid
rd_req_ready_i  input  1  request accepted (AR handshake)
rd_req_addr_o  output  ADDR_WIDTH  burst address
rd_req_alen_o  output  8  beats-1
rd_req_size_o  output  3  log2(BPB)
rd_req_strb_o  output  BPB  byte mask applied to the burst
rd_req_mode_o  output  1  latched mode
busy_o  output  1  descriptor in progress
done_o  output  1  one-cycle completion pulse
aborted_o  output  1  with done_o: run ended by abort
err_o  output  1  with done_o: src_addr_i not BPB-aligned
req_cnt_o  output  16  bursts issued this run (wraps)

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rd_req_size_o = 0.
- States: IDLE, CALC, REQ, DONE.
- IDLE + start_i:
  - Latch addr, mode, full = num_bytes>>log2(BPB), tail = num_bytes mod BPB.
  - Clear req_cnt_o; busy_o=1.
  - If src_addr_i is unaligned: go to DONE with err=1.
  - Else if num_bytes_i=0: go to DONE.
  - Else: go to CALC.
- start_i outside IDLE is ignored.
- CALC (1 cycle), compute beats:
  - full>0, INCR: min(full, MAX_BEATS, (4096 - addr[11:0])/BPB).
  - full>0, FIXED: min(full, 16).
  - full=0, tail>0: beats=1, strb = (1<<tail)-1.
  - Otherwise strb is all ones.
  - Register outputs; go to REQ.
- REQ:
  - rd_req_valid_o=1. All rd_req_* fields are stable until rd_req_ready_i=1.
  - On handshake: req_cnt_o++.
    - If full>0: full -= beats; addr += beats*BPB (INCR only); FIXED keeps addr.
    - Else: tail=0.
    - Next state: DONE if abort latched, or if full=0 and tail=0; otherwise CALC.
  - rd_req_valid_o drops the cycle after the handshake. Request latency: start to first valid = 2 cycles.
- Abort:
  - abort_i in CALC: go to DONE.
  - abort_i in REQ: set the abort latch; valid is never withdrawn before the handshake; DONE follows the handshake.
  - abort_i in IDLE: no effect.
- DONE (1 cycle): done_o=1; aborted_o/err_o reflect the run; busy_o=0 on exit; return to IDLE.
- Width rules:
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - alen = beats-1, truncated to 8 bits (beats <= 256 always).
  - rd_req_size_o = log2(BPB), constant while busy.

Test Plan:
- addr 0x1000, 64B, INCR, ready=1 -> one request: addr 0x1000, alen 15, strb 0xF, size 2; done 1 cycle after handshake; req_cnt=1.
- addr 0x0FF0, 64B, INCR -> requests (0x0FF0, alen 3) then (0x1000, alen 11); no burst crosses 4KB.
- addr 0x2000, 1030B, INCR -> (0x2000, alen 255, strb 0xF), (0x2400, alen 0, strb 0xF), (0x2404, alen 0, strb 0x3); req_cnt=3.
- addr 0x3000, 40B, FIXED -> (0x3000, alen 9); done. Hold ready=0 for 5 cycles during this run -> valid and all fields stable throughout.
- Pulse abort while REQ is stalled on the first of the 3 bursts of the 1030B case -> valid held until ready, then done=1, aborted=1, req_cnt=1, no further valid.
- start with num_bytes=0 -> done 1 cycle later, no valid. start with addr 0x1002 -> done with err=1, no valid. Assert rst mid-REQ -> all outputs 0 immediately.
